// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues one imem read per cycle
// while it has credit, buffers returned words. Optional FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 32,
  parameter int ADDR_STEP = 4
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       redirect,
  input  logic [WIDTH-1:0]           redirect_addr,
  output logic [WIDTH-1:0]           imem_addr,
  input  logic [WIDTH-1:0]           imem_data,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [WIDTH-1:0]           deq_instr,
  output logic [WIDTH-1:0]           deq_addr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] fpc_q, fpc_d;
  logic             inf_q, inf_d;
  logic [WIDTH-1:0] inf_addr_q;
  logic [PW-1:0]    rp_q, rp_d, wp_q, wp_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_instr_q [DEPTH];
  logic [WIDTH-1:0] mem_addr_q  [DEPTH];

  logic [CW:0] credit;
  logic        issue, buf_valid, enq, deq_buf;

  // Credit counts the in-flight word so the queue can never overflow on enqueue.
  always_comb begin
    credit    = {1'b0, count_q} + {{CW{1'b0}}, inf_q};
    issue     = ~redirect & (credit < (CW+1)'(DEPTH));
    buf_valid = (count_q != '0) & ~redirect;
    deq_buf   = buf_valid & deq_ready;
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  always_comb begin
    bypass    = (count_q == '0) & inf_q & ~redirect;
    deq_valid = buf_valid | bypass;
    deq_instr = bypass ? imem_data  : mem_instr_q[rp_q];
    deq_addr  = bypass ? inf_addr_q : mem_addr_q[rp_q];
    enq       = inf_q & ~redirect & ~(bypass & deq_ready);
  end
`else
  always_comb begin
    deq_valid = buf_valid;
    deq_instr = mem_instr_q[rp_q];
    deq_addr  = mem_addr_q[rp_q];
    enq       = inf_q & ~redirect;
  end
`endif

  always_comb begin
    fpc_d   = fpc_q;
    inf_d   = inf_q;
    rp_d    = rp_q;
    wp_d    = wp_q;
    count_d = count_q;
    if (redirect) begin
      fpc_d   = redirect_addr;
      inf_d   = 1'b0;
      rp_d    = '0;
      wp_d    = '0;
      count_d = '0;
    end else begin
      inf_d = issue;
      if (issue)   fpc_d = fpc_q + WIDTH'(ADDR_STEP);
      if (enq)     wp_d  = wp_q + PW'(1);
      if (deq_buf) rp_d  = rp_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(deq_buf);
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      fpc_q   <= '0;
      inf_q   <= 1'b0;
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
    end else begin
      fpc_q   <= fpc_d;
      inf_q   <= inf_d;
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      count_q <= count_d;
    end
  end

  // Data storage carries no reset; validity is tracked by the control state above.
  always_ff @(posedge clk) begin
    if (issue) inf_addr_q <= fpc_q;
    if (nreset && enq) begin
      mem_instr_q[wp_q] <= imem_data;
      mem_addr_q[wp_q]  <= inf_addr_q;
    end
  end

  assign imem_addr = fpc_q;
  assign count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int ADDR_STEP = 4;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [31:0] XORK = 32'hA5A5_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT = BYP ? 1 : 2;

  logic             clk = 1'b0;
  logic             nreset = 1'b0;
  logic             redirect = 1'b0;
  logic [WIDTH-1:0] redirect_addr = '0;
  logic [WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0] imem_data = '0;
  logic             deq_ready = 1'b0;
  logic             deq_valid;
  logic [WIDTH-1:0] deq_instr;
  logic [WIDTH-1:0] deq_addr;
  logic [CW-1:0]    count;

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_STEP(ADDR_STEP)) dut (
    .clk(clk), .nreset(nreset), .redirect(redirect), .redirect_addr(redirect_addr),
    .imem_addr(imem_addr), .imem_data(imem_data), .deq_ready(deq_ready),
    .deq_valid(deq_valid), .deq_instr(deq_instr), .deq_addr(deq_addr), .count(count)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory: word = address ^ XORK, one cycle later.
  always @(posedge clk) imem_data <= imem_addr ^ XORK;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_fpc = '0;
  bit          m_inf = 1'b0;
  logic [31:0] m_inf_addr = '0;
  logic [31:0] m_q[$];
  int          m_enqs = 0;

  function automatic bit e_valid();
    return !redirect && (m_q.size() != 0 || (BYP && m_inf));
  endfunction

  function automatic logic [31:0] e_addr();
    return (m_q.size() != 0) ? m_q[0] : m_inf_addr;
  endfunction

  task automatic model_step();
    int sz;
    bit byp, deq, enq;
    sz  = m_q.size();
    byp = BYP && sz == 0 && m_inf;
    if (!nreset) begin
      m_fpc = '0; m_inf = 1'b0; m_q.delete();
    end else if (redirect) begin
      m_fpc = redirect_addr; m_inf = 1'b0; m_q.delete();
    end else begin
      deq = sz != 0 && deq_ready;
      enq = m_inf && !(byp && deq_ready);
      if (deq) void'(m_q.pop_front());
      if (enq) begin m_q.push_back(m_inf_addr); m_enqs++; end
      if (sz + int'(m_inf) < DEPTH) begin
        m_inf_addr = m_fpc; m_fpc = m_fpc + 32'(ADDR_STEP); m_inf = 1'b1;
      end else m_inf = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    nreset = 1'b0; redirect = 1'b0; deq_ready = 1'b0;
    tick();
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    nreset = 1'b0; redirect = 1'b1; redirect_addr = 32'h200; deq_ready = 1'b1;
    tick(); tick();
    redirect = 1'b0;
    #4;
    checks += 3;
    if (count !== '0) begin errors++; $display("FAIL reset.count got %0d exp 0", count); end
    if (deq_valid !== 1'b0) begin errors++; $display("FAIL reset.valid got %b exp 0", deq_valid); end
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset.imem_addr got %h exp 0", imem_addr); end
    tick();
  endtask

  task automatic test_stream();
    logic [31:0] nxt;
    int first, fires;
    nxt = 0; first = -1; fires = 0;
    nreset = 1'b1; deq_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #4;
      checks += 3;
      if (count !== CW'(m_q.size())) begin errors++; $display("FAIL stream.count got %0d exp %0d", count, m_q.size()); end
      if (deq_valid !== e_valid()) begin errors++; $display("FAIL stream.valid got %b exp %b", deq_valid, e_valid()); end
      if (imem_addr !== m_fpc) begin errors++; $display("FAIL stream.imem_addr got %h exp %h", imem_addr, m_fpc); end
      if (e_valid()) begin
        checks++;
        if (deq_addr !== e_addr() || deq_instr !== (e_addr() ^ XORK)) begin
          errors++; $display("FAIL stream.data got %h/%h exp %h/%h", deq_addr, deq_instr, e_addr(), e_addr() ^ XORK);
        end
      end
      if (deq_valid && deq_ready) begin
        if (first < 0) first = c;
        checks++;
        if (deq_addr !== nxt) begin errors++; $display("FAIL stream.order got %h exp %h", deq_addr, nxt); end
        nxt += 4; fires++;
      end
      tick();
    end
    checks += 2;
    if (first != LAT) begin errors++; $display("FAIL stream.latency got %0d exp %0d", first, LAT); end
    if (fires != 16 - LAT) begin errors++; $display("FAIL stream.rate got %0d exp %0d", fires, 16 - LAT); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      #4;
      checks += 2;
      if (count !== CW'(m_q.size())) begin errors++; $display("FAIL bp.count got %0d exp %0d", count, m_q.size()); end
      if (imem_addr !== m_fpc) begin errors++; $display("FAIL bp.imem_addr got %h exp %h", imem_addr, m_fpc); end
      if (c == 9) begin
        checks += 2;
        if (count !== CW'(DEPTH)) begin errors++; $display("FAIL bp.full got %0d exp %0d", count, DEPTH); end
        if (imem_addr !== 32'd16) begin errors++; $display("FAIL bp.hold got %h exp 10", imem_addr); end
      end
      tick();
    end
    deq_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #4;
      checks += 2;
      if (count !== CW'(m_q.size())) begin errors++; $display("FAIL bp.drain_count got %0d exp %0d", count, m_q.size()); end
      if (deq_valid !== 1'b1 || deq_addr !== 32'(4 * k) || deq_instr !== (32'(4 * k) ^ XORK)) begin
        errors++; $display("FAIL bp.drain v=%b got %h/%h exp %h", deq_valid, deq_addr, deq_instr, 32'(4 * k));
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    logic [31:0] nxt;
    int first, fires;
    do_reset();
    deq_ready = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    redirect = 1'b1; redirect_addr = 32'h100;
    #4;
    checks++;
    if (deq_valid !== 1'b0) begin errors++; $display("FAIL redir.valid got %b exp 0", deq_valid); end
    tick();
    redirect = 1'b0;
    nxt = 32'h100; first = -1; fires = 0;
    for (int k = 1; k <= 6; k++) begin
      #4;
      checks += 2;
      if (count !== CW'(m_q.size())) begin errors++; $display("FAIL redir.count got %0d exp %0d", count, m_q.size()); end
      if (deq_valid !== e_valid()) begin errors++; $display("FAIL redir.model_valid got %b exp %b", deq_valid, e_valid()); end
      if (deq_valid && deq_ready) begin
        if (first < 0) first = k;
        checks++;
        if (deq_addr !== nxt || deq_instr !== (nxt ^ XORK)) begin errors++; $display("FAIL redir.order got %h exp %h", deq_addr, nxt); end
        nxt += 4; fires++;
      end
      tick();
    end
    checks += 2;
    if (first != LAT + 1) begin errors++; $display("FAIL redir.latency got %0d exp %0d", first, LAT + 1); end
    if (fires < 2) begin errors++; $display("FAIL redir.fires got %0d exp >=2", fires); end
  endtask

  task automatic test_redirect_full();
    int first;
    do_reset();
    for (int c = 0; c < 8; c++) tick();
    redirect = 1'b1; redirect_addr = 32'h300; deq_ready = 1'b1;
    #4;
    checks += 2;
    if (count !== CW'(DEPTH)) begin errors++; $display("FAIL rfull.pre_count got %0d exp %0d", count, DEPTH); end
    if (deq_valid !== 1'b0) begin errors++; $display("FAIL rfull.valid got %b exp 0", deq_valid); end
    tick();
    redirect = 1'b0;
    #4;
    checks += 3;
    if (count !== '0) begin errors++; $display("FAIL rfull.count got %0d exp 0", count); end
    if (deq_valid !== 1'b0) begin errors++; $display("FAIL rfull.stale got %b exp 0", deq_valid); end
    if (imem_addr !== 32'h300) begin errors++; $display("FAIL rfull.imem_addr got %h exp 300", imem_addr); end
    tick();
    first = -1;
    for (int k = 2; k < 6; k++) begin
      #4;
      checks++;
      if (count !== CW'(m_q.size()) || deq_valid !== e_valid()) begin
        errors++; $display("FAIL rfull.model got %0d/%b exp %0d/%b", count, deq_valid, m_q.size(), e_valid());
      end
      if (deq_valid && first < 0) begin
        first = k; checks++;
        if (deq_addr !== 32'h300) begin errors++; $display("FAIL rfull.first got %h exp 300", deq_addr); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int first;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #4;
      if (count == CW'(3)) begin found = 1'b1; break; end
      tick();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rmid.reach got %0d exp 3", count); end
    nreset = 1'b0;
    tick();
    nreset = 1'b1; deq_ready = 1'b1;
    #4;
    checks += 3;
    if (count !== '0) begin errors++; $display("FAIL rmid.count got %0d exp 0", count); end
    if (deq_valid !== 1'b0) begin errors++; $display("FAIL rmid.valid got %b exp 0", deq_valid); end
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL rmid.imem_addr got %h exp 0", imem_addr); end
    tick();
    first = -1;
    for (int k = 1; k < 5; k++) begin
      #4;
      if (deq_valid && first < 0) begin
        first = k; checks++;
        if (deq_addr !== 32'h0 || deq_instr !== XORK) begin errors++; $display("FAIL rmid.restart got %h exp 0", deq_addr); end
      end
      tick();
    end
    checks++;
    if (first != LAT) begin errors++; $display("FAIL rmid.latency got %0d exp %0d", first, LAT); end
  endtask

  task automatic test_wrap();
    int start, cyc;
    logic [31:0] nxt;
    do_reset();
    start = m_enqs; nxt = 0; cyc = 0;
    while (m_enqs - start < 3 * DEPTH + 1 && cyc < 300) begin
      deq_ready = 1'($urandom_range(0, 1));
      #4;
      checks += 3;
      if (count !== CW'(m_q.size())) begin errors++; $display("FAIL wrap.count got %0d exp %0d", count, m_q.size()); end
      if (count > CW'(DEPTH)) begin errors++; $display("FAIL wrap.overflow got %0d exp <=%0d", count, DEPTH); end
      if (deq_valid !== e_valid()) begin errors++; $display("FAIL wrap.valid got %b exp %b", deq_valid, e_valid()); end
      if (deq_valid && deq_ready) begin
        checks++;
        if (deq_addr !== nxt || deq_instr !== (nxt ^ XORK)) begin errors++; $display("FAIL wrap.order got %h exp %h", deq_addr, nxt); end
        nxt += 4;
      end
      tick();
      cyc++;
    end
    checks++;
    if (m_enqs - start < 3 * DEPTH + 1) begin errors++; $display("FAIL wrap.timeout got %0d exp %0d", m_enqs - start, 3 * DEPTH + 1); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_full();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
